// File: rtl/servo_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_pkg
// Purpose  : Shared types, default parameter values and the counter-width
//            helper for the servo PWM driver and its slew sub-module.
// Contents : state_t    - driver FSM states
//            c_*        - default parameter values (50 MHz, 20 ms frame)
//            cnt_width  - bits needed to hold 0 .. frame_cycles-1
// Revision : 1.0 - initial release
// ============================================================================
package servo_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME0 = 2'd1,
    PRIME1 = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int unsigned c_frame_cycles = 1_000_000;
  localparam int unsigned c_min_cycles   = 50_000;
  localparam int unsigned c_step_cycles  = 196;
  localparam int unsigned c_slew_max     = 4;
  localparam logic [7:0]  c_init_pos     = 8'd128;

  // ceil(log2(frame_cycles)), never less than 1. Large enough for the frame
  // counter and for any legal pulse width (which is always < frame_cycles).
  function automatic int unsigned cnt_width(input int unsigned frame_cycles);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(frame_cycles)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : servo_pwm_pkg
`default_nettype wire

// File: rtl/servo_slew.sv
`default_nettype none
// ============================================================================
// Module   : servo_slew
// Purpose  : Holds the applied servo position and moves it toward the target
//            by at most SLEW_MAX per update (0 = jump straight to target).
// Ports    : clk       in   system clock
//            rst_n     in   asynchronous active-low reset (pos <- INIT_POS)
//            update_i  in   one-cycle strobe: sample value_i and step pos
//            value_i   in   target position
//            pos_o     out  current position
// Revision : 1.0 - initial release
// ============================================================================
module servo_slew
  import servo_pwm_pkg::*;
#(
  parameter int unsigned SLEW_MAX = c_slew_max,
  parameter logic [7:0]  INIT_POS = c_init_pos
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update_i,
  input  logic [7:0] value_i,
  output logic [7:0] pos_o
);

  // Only used when |d| > SLEW_MAX, which implies SLEW_MAX < 255.
  localparam logic [7:0] c_step = (SLEW_MAX > 255) ? 8'd255 : SLEW_MAX[7:0];

  logic [7:0] pos_q;
  logic [7:0] pos_d;
  logic [8:0] w_diff;   // two's complement value - pos; bit 8 is the sign
  logic [8:0] w_mag;

  always_comb begin
    pos_d  = pos_q;
    w_diff = {1'b0, value_i} - {1'b0, pos_q};
    w_mag  = w_diff[8] ? (~w_diff + 9'd1) : w_diff;
    if (update_i) begin
      if ((SLEW_MAX == 0) || (32'(w_mag) <= SLEW_MAX)) begin
        pos_d = value_i;
      end else if (w_diff[8]) begin
        // Target is more than c_step below pos, so this cannot underflow.
        pos_d = pos_q - c_step;
      end else begin
        // Target is more than c_step above pos, so this cannot overflow.
        pos_d = pos_q + c_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= INIT_POS;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o = pos_q;

endmodule : servo_slew
`default_nettype wire

// File: rtl/servo_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_driver
// Purpose  : One hobby-servo PWM channel. Once per frame the position is
//            slew-limited toward value_i, converted to a pulse width of
//            MIN_CYCLES + pos * STEP_CYCLES and loaded at the frame boundary.
// Ports    : clk            in   system clock
//            rst_n          in   asynchronous active-low reset
//            enable_i       in   run request (level)
//            value_i        in   target position, 0..255
//            pwm_o          out  servo control pulse (registered)
//            frame_start_o  out  one-cycle pulse on cnt == 0 (registered)
//            pos_o          out  position currently applied
//            active_o       out  high in PRIME0, PRIME1 and RUN (registered)
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_driver
  import servo_pwm_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = c_frame_cycles,
  parameter int unsigned MIN_CYCLES   = c_min_cycles,
  parameter int unsigned STEP_CYCLES  = c_step_cycles,
  parameter int unsigned SLEW_MAX     = c_slew_max,
  parameter logic [7:0]  INIT_POS     = c_init_pos
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  input  logic [7:0] value_i,
  output logic       pwm_o,
  output logic       frame_start_o,
  output logic [7:0] pos_o,
  output logic       active_o
);

  localparam int unsigned   c_cw   = cnt_width(FRAME_CYCLES);
  localparam logic [c_cw-1:0] c_last = c_cw'(FRAME_CYCLES - 1);
  localparam logic [c_cw-1:0] c_upd  = c_cw'(FRAME_CYCLES - 2);
  localparam logic [c_cw-1:0] c_min  = c_cw'(MIN_CYCLES);
  localparam logic [c_cw-1:0] c_step = c_cw'(STEP_CYCLES);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  state_t          state_q, state_d;
  logic [c_cw-1:0] cnt_q, cnt_d;
  logic [c_cw-1:0] high_q, high_d;
  logic            pwm_q, pwm_d;
  logic            fs_q, fs_d;
  logic            active_q, active_d;
  logic            w_update;
  logic [7:0]      w_pos;
  logic [c_cw-1:0] w_width;

  servo_slew #(
    .SLEW_MAX (SLEW_MAX),
    .INIT_POS (INIT_POS)
  ) u_slew (
    .clk      (clk),
    .rst_n    (rst_n),
    .update_i (w_update),
    .value_i  (value_i),
    .pos_o    (w_pos)
  );

  // The parameter constraint keeps the product below FRAME_CYCLES, so the
  // counter width is sufficient and nothing is lost.
  assign w_width = c_min + c_cw'(w_pos) * c_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    w_update = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) state_d = PRIME0;
      end
      PRIME0: begin
        w_update = 1'b1;
        state_d  = enable_i ? PRIME1 : IDLE;
      end
      PRIME1: begin
        high_d  = w_width;
        cnt_d   = '0;
        state_d = enable_i ? RUN : IDLE;
      end
      RUN: begin
        // pos moves one cycle before the wrap so the width computed from it
        // is ready to load on the last cycle of the frame.
        if (cnt_q == c_upd) w_update = 1'b1;
        if (cnt_q == c_last) begin
          cnt_d  = '0;
          high_d = w_width;
          // A disable only takes effect here, so a started frame always
          // completes in full.
          if (!enable_i) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next-state values so that they line
    // up with the counter value held during the same cycle.
    pwm_d    = (state_d == RUN) && (cnt_d < high_d);
    fs_d     = (state_d == RUN) && (cnt_d == '0);
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      high_q   <= '0;
      pwm_q    <= 1'b0;
      fs_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      pwm_q    <= pwm_d;
      fs_q     <= fs_d;
      active_q <= active_d;
    end
  end

  assign pwm_o         = pwm_q;
  assign frame_start_o = fs_q;
  assign active_o      = active_q;
  assign pos_o         = w_pos;

endmodule : servo_pwm_driver
`default_nettype wire

// File: tb/tb_servo_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_driver
// Purpose  : Self-checking bench for servo_pwm_driver. Two instances share
//            clock, reset and enable: one slew-limited (SLEW_MAX = 4) and one
//            unlimited (SLEW_MAX = 0). Expected per-frame pulse widths and
//            positions are queued by the stimulus and compared by a monitor
//            that measures each frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_driver;

  localparam int F    = 1000;
  localparam int MINC = 100;
  localparam int STEP = 2;
  localparam int SLEW = 4;
  localparam int INIT = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] value = 8'd128;
  logic [7:0] value0 = 8'd0;

  logic       pwm, fs, active;
  logic [7:0] pos;
  logic       pwm0, fs0, active0;
  logic [7:0] pos0;

  always #5 clk = ~clk;

  servo_pwm_driver #(
    .FRAME_CYCLES (F), .MIN_CYCLES (MINC), .STEP_CYCLES (STEP),
    .SLEW_MAX (SLEW), .INIT_POS (8'(INIT))
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable_i (enable), .value_i (value),
    .pwm_o (pwm), .frame_start_o (fs), .pos_o (pos), .active_o (active)
  );

  servo_pwm_driver #(
    .FRAME_CYCLES (F), .MIN_CYCLES (MINC), .STEP_CYCLES (STEP),
    .SLEW_MAX (0), .INIT_POS (8'(INIT))
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .enable_i (enable), .value_i (value0),
    .pwm_o (pwm0), .frame_start_o (fs0), .pos_o (pos0), .active_o (active0)
  );

  typedef struct {
    int width;
    int pos;
    int width0;
    int pos0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pos_m  = INIT;
  int   pos0_m = INIT;
  int   fs_count = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules: move toward the target by at most s, or jump if s == 0.
  function automatic int next_pos(input int p, input int v, input int s);
    int d;
    d = v - p;
    if (s == 0 || (d <= s && d >= -s)) return v;
    return (d > 0) ? p + s : p - s;
  endfunction

  function automatic int width_of(input int p);
    return MINC + p * STEP;
  endfunction

  // Apply one position update with the targets currently driven and queue
  // what the frame that uses it must look like.
  task automatic push_next();
    exp_t e;
    pos_m  = next_pos(pos_m, int'(value), SLEW);
    pos0_m = next_pos(pos0_m, int'(value0), 0);
    e.width  = width_of(pos_m);
    e.pos    = pos_m;
    e.width0 = width_of(pos0_m);
    e.pos0   = pos0_m;
    exp_q.push_back(e);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < F + 100);
    if (!fs) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout: no frame_start within %0d cycles", n);
    end
  endtask

  task automatic start(input int v, input int v0);
    int n;
    value  = 8'(v);
    value0 = 8'(v0);
    push_next();
    enable = 1'b1;
    wait_fs(n);
    check("enable_latency", n, 3);
  endtask

  // Called on a frame_start cycle: set the targets for this frame, queue the
  // next frame's expectation and run to the next frame_start.
  task automatic frame(input int v, input int v0);
    int n;
    value  = 8'(v);
    value0 = 8'(v0);
    push_next();
    wait_fs(n);
  endtask

  // ---------------------------------------------------------------- monitor
  int len = 0, hi = 0, hi0 = 0, pos_at = 0, pos0_at = 0;
  bit in_frame = 1'b0;

  task automatic close_frame();
    exp_t e;
    in_frame = 1'b0;
    check("frame_length", len, F);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: frame with width %0d had no expectation", hi);
    end else begin
      e = exp_q.pop_front();
      check("pulse_width", hi, e.width);
      check("pos", pos_at, e.pos);
      check("pulse_width_noslew", hi0, e.width0);
      check("pos_noslew", pos0_at, e.pos0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame && (fs || !active)) close_frame();
      if (fs) begin
        fs_count++;
        in_frame = 1'b1;
        len = 0;
        hi = 0;
        hi0 = 0;
        pos_at = int'(pos);
        pos0_at = int'(pos0);
      end
      if (in_frame) begin
        len++;
        hi  += int'(pwm);
        hi0 += int'(pwm0);
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    int fc;
    int v;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_fs", int'(fs), 0);
    check("reset_active", int'(active), 0);
    check("reset_pos", int'(pos), INIT);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_active", int'(active), 0);

    // Enable; unlimited instance goes 0 -> 255
    start(128, 0);
    frame(128, 255);

    // Step to 200 with slew limiting, then steady
    for (int i = 0; i < 20; i++) frame(200, int'($urandom_range(0, 255)));

    // Within slew: exact jump
    frame(203, 17);

    // Late change at cnt = F-1 must not affect the next frame
    value = 8'd203;
    push_next();
    repeat (F - 1) @(negedge clk);
    value = 8'd150;
    wait_fs(n);
    frame(150, 90);
    frame(150, 91);

    // Randomized frames: mix of small and large moves
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = pos_m + int'($urandom_range(0, 10)) - 5;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
      end else begin
        v = int'($urandom_range(0, 255));
      end
      frame(v, int'($urandom_range(0, 255)));
    end

    // Disable mid-pulse: the frame completes, then IDLE
    value  = 8'($urandom_range(0, 255));
    value0 = 8'($urandom_range(0, 255));
    repeat (50) @(negedge clk);
    enable = 1'b0;
    pos_m  = next_pos(pos_m, int'(value), SLEW);
    pos0_m = next_pos(pos0_m, int'(value0), 0);
    fc = fs_count;
    repeat (F + 100) @(negedge clk);
    check("disable_no_fs", fs_count, fc);
    check("disable_active", int'(active), 0);
    check("disable_pwm", int'(pwm), 0);
    check("disable_pos_held", int'(pos), pos_m);
    check("disable_pos_held_noslew", int'(pos0), pos0_m);
    check("disable_queue_drained", exp_q.size(), 0);

    // Re-enable: position carries on from where it was held
    start(128, 128);
    frame(128, 128);
    frame(128, 128);

    // Asynchronous reset mid-pulse at cnt = 200
    repeat (200) @(negedge clk);
    check("pre_reset_pwm", int'(pwm), (200 < width_of(pos_m)) ? 1 : 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_active", int'(active), 0);
    check("async_reset_pos", int'(pos), INIT);
    exp_q.delete();
    pos_m  = INIT;
    pos0_m = INIT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_idle", int'(active), 0);
    start(128, 128);
    frame(128, 128);
    frame(128, 128);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_servo_pwm_driver
`default_nettype wire
